pipe_adder_n: RTL

Parametrised, fully pipelined ripple-carry adder. Operands of WIDTH bits are split into SEG-bit segments, with one segment resolved per clock and the carry registered between stages. It accepts one operation per cycle and tags each result with a valid bit. A pipeline-wide hold freezes in-flight work. It is the general-width successor to the fixed 4-bit bit-serial pipelined adder and serves datapaths that need 32/64-bit sums at full clock rate.

---
 rtl/pipe_adder_n.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pipe_adder_n.sv
// pipe_adder_n: WIDTH-bit ripple-carry adder resolving SEG bits per stage with the carry registered between stages.
// Latency: STAGES+1 cycles from operand sample to registered s/cout/ovf (STAGES = WIDTH/SEG); 1 op/cycle.
// Backpressure: none beyond hold, which freezes every register; define PIPE_ADDER_SUB_EN to enable subtract mode.
module pipe_adder_n #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG;

    if ((SEG < 1) || ((WIDTH % SEG) != 0)) begin : g_bad_cfg
        $error("pipe_adder_n: WIDTH must be a non-zero multiple of SEG");
    end

    // Level k holds what stage k consumes; level 0 is the input register.
    // Operands ride along whole; only segment k is read at stage k, which
    // gives the input skew, and the partially built sum rides along to
    // give the output deskew.
    logic             v_q   [0:STAGES];
    logic             c_q   [0:STAGES];
    logic [WIDTH-1:0] a_q   [0:STAGES-1];
    logic [WIDTH-1:0] b_q   [0:STAGES-1];
    logic [WIDTH-1:0] sum_q [1:STAGES];
    logic             ovf_q;
`ifdef PIPE_ADDER_SUB_EN
    logic             sub_q [0:STAGES-1];
`else
    logic             unused_sub;
    assign unused_sub = sub;
`endif

    logic             out_valid_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_out_q;

    // Input stage: capture operands, valid and the stage-0 carry-in
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q[0] <= 1'b0;
        end else if (!hold) begin
            v_q[0] <= in_valid;
            a_q[0] <= a;
            b_q[0] <= b;
`ifdef PIPE_ADDER_SUB_EN
            sub_q[0] <= sub;
            // Subtract is A + ~B + 1, so the external carry-in is replaced.
            c_q[0]   <= sub | cin;
`else
            c_q[0]   <= cin;
`endif
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0]   a_seg;
        logic [SEG-1:0]   b_seg;
        logic [SEG-1:0]   seg_sum;
        logic             seg_c;
        logic [WIDTH-1:0] sum_d;

        assign a_seg = a_q[k][k*SEG +: SEG];
`ifdef PIPE_ADDER_SUB_EN
        assign b_seg = b_q[k][k*SEG +: SEG] ^ {SEG{sub_q[k]}};
`else
        assign b_seg = b_q[k][k*SEG +: SEG];
`endif
        assign {seg_c, seg_sum} = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, c_q[k]};

        if (k == 0) begin : g_first
            // Seed the sum word with the lowest segment
            always_comb begin
                sum_d          = '0;
                sum_d[SEG-1:0] = seg_sum;
            end
        end else begin : g_next
            // Insert this stage's segment into the sum carried from below
            always_comb begin
                sum_d                = sum_q[k];
                sum_d[k*SEG +: SEG]  = seg_sum;
            end
        end

        // Stage register: valid, carry out and accumulated sum
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q[k+1] <= 1'b0;
            end else if (!hold) begin
                v_q[k+1]   <= v_q[k];
                c_q[k+1]   <= seg_c;
                sum_q[k+1] <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Carry the unconsumed operands (and mode) to the next stage
            always_ff @(posedge clk) begin
                if (!hold) begin
                    a_q[k+1] <= a_q[k];
                    b_q[k+1] <= b_q[k];
`ifdef PIPE_ADDER_SUB_EN
                    sub_q[k+1] <= sub_q[k];
`endif
                end
            end
        end else begin : g_last
            logic ovf_d;
            // Carry into the MSB is recovered as a ^ b ^ sum at that bit
            assign ovf_d = a_seg[SEG-1] ^ b_seg[SEG-1] ^ seg_sum[SEG-1] ^ seg_c;

            // Register overflow alongside the final carry
            always_ff @(posedge clk) begin
                if (!hold) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    // The last stage reads only its own segment; lower operand bits are dead
    // there and get pruned in synthesis.
    logic unused_tail;
    assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1]};

    // Output register: pulse valid per result, keep last result otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_out_q   <= 1'b0;
        end else if (!hold) begin
            out_valid_q <= v_q[STAGES];
            if (v_q[STAGES]) begin
                s_q       <= sum_q[STAGES];
                cout_q    <= c_q[STAGES];
                ovf_out_q <= ovf_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_out_q;

endmodule
